// File: rtl/md_ctrl.sv
// md_ctrl: sequencing controller for the fixed-latency multiply/divide
// datapath. It issues begin pulses, holds the operands stable, counts the
// latency, stalls EX, and owns HI/LO. Results of flushed ops are dropped.
module md_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 6,
  parameter int DIV_LAT = 35
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       dp_begin,
  output logic [3:0]       dp_m,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_hi,
  input  logic [WIDTH-1:0] dp_lo,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic is_mul, is_div, is_md;
  logic issue, mt_ok, res_wr;

  assign is_mul = (req_op == 4'd5) || (req_op == 4'd6);
  assign is_div = (req_op == 4'd7) || (req_op == 4'd11);
  assign is_md  = is_mul || is_div;

  // Gated by resetn so no begin pulse or stall can escape while in reset.
  assign issue  = resetn && (state_q == IDLE) && req_valid && is_md && !flush;
  // HI/LO moves run in IDLE and while a flushed op drains.
  assign mt_ok  = ((state_q == IDLE) || (state_q == DRAIN)) && req_valid && !flush;
  // The datapath result is valid in the last BUSY cycle.
  assign res_wr = (state_q == BUSY) && (cnt_q == CW'(1)) && !flush;

  // State and latency counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: issue, count down, complete or drain a flushed op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = BUSY;
          cnt_d   = is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (flush)                 state_d = DRAIN;
        else if (cnt_q == CW'(1))  state_d = DONE;
      end
      DONE: state_d = IDLE;
      DRAIN: begin
        // The datapath is still busy with the discarded op; wait it out.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: stall, begin pulse, datapath operands, move-from read data
  always_comb begin
    stall    = 1'b0;
    dp_begin = 2'd0;
    dp_m     = op_q;
    dp_a     = a_q;
    dp_b     = b_q;
    rd_data  = '0;
    case (state_q)
      IDLE:  stall = issue;
      BUSY:  stall = !flush;
      DONE:  stall = 1'b0;
      // A new mult/div waits here until the drained op has left the datapath.
      DRAIN: stall = req_valid && is_md && !flush;
      default: stall = 1'b0;
    endcase
    if (issue) begin
      dp_begin = is_mul ? 2'd2 : 2'd1;
      dp_m     = req_op;
      dp_a     = req_a;
      dp_b     = req_b;
    end
    if (state_q != BUSY) begin
      if (req_op == 4'd14)      rd_data = hi_q;
      else if (req_op == 4'd15) rd_data = lo_q;
    end
  end

  // Operand latches held for the datapath for the whole operation
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (issue) begin
      op_q <= req_op;
      a_q  <= req_a;
      b_q  <= req_b;
    end
  end

  // Architectural HI/LO: datapath result on completion, or MTHI/MTLO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (res_wr) begin
      hi_q <= dp_hi;
      lo_q <= dp_lo;
    end else if (mt_ok) begin
      if (req_op == 4'd12) hi_q <= req_a;
      if (req_op == 4'd13) lo_q <= req_a;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl with a fixed-latency datapath model.
module tb_md_ctrl;
  localparam int W  = 32;
  localparam int ML = 6;
  localparam int DL = 35;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic [3:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         flush;
  logic         stall;
  logic [W-1:0] rd_data;
  logic [1:0]   dp_begin;
  logic [3:0]   dp_m;
  logic [W-1:0] dp_a, dp_b, dp_hi, dp_lo, hi_q, lo_q;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb[$];

  md_ctrl #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .rd_data(rd_data), .dp_begin(dp_begin), .dp_m(dp_m), .dp_a(dp_a),
    .dp_b(dp_b), .dp_hi(dp_hi), .dp_lo(dp_lo), .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Datapath model: result valid only in the cycle LAT cycles after begin.
  function automatic logic [63:0] dp_calc(logic [3:0] m, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb2;
    logic [63:0] ua, ub;
    int si, sj;
    sa = longint'($signed(a)); sb2 = longint'($signed(b));
    ua = {32'd0, a}; ub = {32'd0, b};
    si = $signed(a); sj = $signed(b);
    case (m)
      4'd5:  return sa * sb2;
      4'd6:  return ua * ub;
      4'd11: return (b == 0) ? 64'd0 : {32'(si % sj), 32'(si / sj)};
      4'd7:  return (b == 0) ? 64'd0 : {a % b, a / b};
      default: return 64'd0;
    endcase
  endfunction

  logic         pend;
  int           tmr;
  logic [63:0]  res;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= 1'b0; tmr <= 0; res <= '0;
    end else if (dp_begin != 2'd0) begin
      pend <= 1'b1;
      tmr  <= (dp_begin == 2'd2) ? ML - 1 : DL - 1;
      res  <= dp_calc(dp_m, dp_a, dp_b);
    end else if (pend) begin
      if (tmr == 0) pend <= 1'b0;
      else          tmr  <= tmr - 1;
    end
  end
  assign dp_hi = (pend && tmr == 0) ? res[63:32] : 32'hBADBAD00;
  assign dp_lo = (pend && tmr == 0) ? res[31:0]  : 32'h0BAD0BAD;

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic fl);
    req_valid = v; req_op = op; req_a = a; req_b = b; flush = fl;
  endtask

  // Counts stalled cycles from the current one; leaves us in the first unstalled cycle.
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (stall && n < 200) begin
      n++;
      if (dp_begin != 2'd0) nb++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({stall, dp_begin, dp_m, dp_a, dp_b, hi_q, lo_q, rd_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got stall=%b beg=%0d m=%0d hi=%h lo=%h req=all zero",
               stall, dp_begin, dp_m, hi_q, lo_q);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_mult;
    int n, nb; logic [63:0] e;
    @(negedge clk); drive(1, 4'd5, 32'hFFFFFFFD, 32'd7, 0);
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    #1;
    checks++;
    if (dp_begin !== 2'd2) begin failures++; $display("FAIL mult_begin got=%0d exp=2", dp_begin); end
    wait_done(n, nb);
    checks++;
    if (n !== 7 || nb !== 1) begin failures++; $display("FAIL mult_stall got=%0d/%0d exp=7/1", n, nb); end
    checks++;
    if ({stall, dp_begin} !== 3'd0) begin failures++; $display("FAIL mult_done_noreissue got=%b%0d exp=00", stall, dp_begin); end
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL mult_hilo got=%h exp=%h", {hi_q, lo_q}, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0); #1;
    checks++;
    if ({stall, dp_begin} !== 3'd0) begin failures++; $display("FAIL mult_after_done got=%b%0d exp=00", stall, dp_begin); end
  endtask

  task automatic test_divu;
    int n, bad; logic [63:0] e;
    @(negedge clk); drive(1, 4'd7, 32'd100, 32'd7, 0);
    sb.push_back({32'd2, 32'd14});
    #1;
    checks++;
    if (dp_begin !== 2'd1) begin failures++; $display("FAIL divu_begin got=%0d exp=1", dp_begin); end
    n = 1; bad = 0;
    // Scramble the request operands; the datapath must keep seeing the latched ones.
    @(negedge clk); req_a = 32'hDEADBEEF; req_b = 32'd0; #1;
    while (stall && n < 200) begin
      n++;
      if ({dp_m, dp_a, dp_b} !== {4'd7, 32'd100, 32'd7} || dp_begin !== 2'd0) bad++;
      @(negedge clk); #1;
    end
    checks++;
    if (n !== 36) begin failures++; $display("FAIL divu_stall got=%0d exp=36", n); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL divu_operands_stable got=%0d bad cycles exp=0", bad); end
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL divu_hilo got=%h exp=%h", {hi_q, lo_q}, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    int n, nb; logic [63:0] e;
    @(negedge clk); drive(1, 4'd6, 32'hFFFFFFFF, 32'd2, 0);
    sb.push_back({32'd1, 32'hFFFFFFFE});
    #1; wait_done(n, nb);
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e || n !== 7) begin failures++; $display("FAIL multu_hilo got=%h n=%0d exp=%h n=7", {hi_q, lo_q}, n, e); end
    @(negedge clk); drive(1, 4'd11, 32'hFFFFFF9C, 32'd7, 0);
    sb.push_back({32'hFFFFFFFE, 32'hFFFFFFF2});
    #1;
    checks++;
    if (dp_begin !== 2'd1) begin failures++; $display("FAIL b2b_div_begin got=%0d exp=1", dp_begin); end
    wait_done(n, nb);
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e || n !== 36) begin failures++; $display("FAIL div_signed_hilo got=%h n=%0d exp=%h n=36", {hi_q, lo_q}, n, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_mt_mf;
    @(negedge clk); drive(1, 4'd12, 32'h1234, 0, 0); #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL mthi_nostall got=%b exp=0", stall); end
    @(negedge clk); drive(1, 4'd14, 0, 0, 0); #1;
    checks++;
    if ({stall, rd_data} !== {1'b0, 32'h1234}) begin failures++; $display("FAIL mfhi_read got=%b/%h exp=0/00001234", stall, rd_data); end
    @(negedge clk); drive(1, 4'd13, 32'h5678, 0, 0);
    @(negedge clk); drive(1, 4'd15, 0, 0, 0); #1;
    checks++;
    if (rd_data !== 32'h5678) begin failures++; $display("FAIL mflo_read got=%h exp=00005678", rd_data); end
    @(negedge clk); drive(1, 4'd0, 32'hFFFF, 0, 0); #1;
    checks++;
    if ({stall, rd_data} !== 33'd0) begin failures++; $display("FAIL noop_read got=%b/%h exp=0/0", stall, rd_data); end
  endtask

  task automatic test_flush_idle;
    int n, nb; logic [63:0] e;
    @(negedge clk); drive(1, 4'd5, 32'd3, 32'd4, 1); #1;
    checks++;
    if ({dp_begin, stall} !== 3'd0) begin failures++; $display("FAIL flush_idle_nobegin got=%0d/%b exp=0/0", dp_begin, stall); end
    @(negedge clk); drive(1, 4'd12, 32'hFFFF, 0, 1);
    @(negedge clk); drive(0, 4'd0, 0, 0, 0); #1;
    checks++;
    if (hi_q !== 32'h1234) begin failures++; $display("FAIL flush_idle_mt_suppressed got=%h exp=00001234", hi_q); end
    @(negedge clk); drive(1, 4'd5, 32'd3, 32'd4, 0);
    sb.push_back({32'd0, 32'd12});
    #1;
    checks++;
    if (dp_begin !== 2'd2) begin failures++; $display("FAIL flush_idle_state_idle got=%0d exp=2", dp_begin); end
    wait_done(n, nb);
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e || n !== 7) begin failures++; $display("FAIL flush_idle_mult got=%h n=%0d exp=%h n=7", {hi_q, lo_q}, n, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_flush_drain;
    int n, nb; logic [63:0] e; logic [W-1:0] oh;
    oh = hi_q;
    @(negedge clk); drive(1, 4'd11, 32'd100, 32'd7, 0);
    for (int k = 1; k <= 9; k++) @(negedge clk);
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL flush_busy_stall_drop got=%b exp=0", stall); end
    // Drained result must not land; the MTLO below must survive.
    sb.push_back({oh, 32'hAAAA});
    @(negedge clk); drive(1, 4'd13, 32'hAAAA, 0, 0); #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL drain_mt_nostall got=%b exp=0", stall); end
    @(negedge clk); drive(1, 4'd5, 32'd5, 32'd6, 0); #1;
    n = 0;
    while (stall && dp_begin == 2'd0 && n < 200) begin n++; @(negedge clk); #1; end
    checks++;
    if (n !== 24 || dp_begin !== 2'd2) begin failures++; $display("FAIL drain_stall_cycles got=%0d beg=%0d exp=24 beg=2", n, dp_begin); end
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL drain_hilo_kept got=%h exp=%h", {hi_q, lo_q}, e); end
    sb.push_back({32'd0, 32'd30});
    wait_done(n, nb);
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e || n !== 7) begin failures++; $display("FAIL drain_then_mult got=%h n=%0d exp=%h n=7", {hi_q, lo_q}, n, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0);
  endtask

  task automatic test_reset_mid;
    int n, nb; logic [63:0] e;
    @(negedge clk); drive(1, 4'd5, 32'd7, 32'd8, 0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    resetn = 1'b0; #1;
    checks++;
    if ({stall, dp_begin, dp_m, dp_a, dp_b, hi_q, lo_q} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got stall=%b beg=%0d m=%0d a=%h hi=%h lo=%h exp=all zero",
               stall, dp_begin, dp_m, dp_a, hi_q, lo_q);
    end
    @(negedge clk); resetn = 1'b1; #1;
    sb.push_back({32'd0, 32'd56});
    checks++;
    if (dp_begin !== 2'd2) begin failures++; $display("FAIL reset_mid_reissue got=%0d exp=2", dp_begin); end
    wait_done(n, nb);
    e = sb.pop_front();
    checks++;
    if ({hi_q, lo_q} !== e || n !== 7) begin failures++; $display("FAIL reset_mid_mult got=%h n=%0d exp=%h n=7", {hi_q, lo_q}, n, e); end
    @(negedge clk); drive(0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 4'd0, 0, 0, 0);
    test_reset;
    test_mult;
    test_divu;
    test_back_to_back;
    test_mt_mf;
    test_flush_idle;
    test_flush_drain;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
